// File: rtl/aec_pkg.sv
// Shared types for the arithmetic-expression transmitter: token codes, ASCII constants, FSM states.
// Optional paren checking in aec_tx is enabled by defining AEC_TX_PAREN_CHECK_EN.
package aec_pkg;

    typedef enum logic [4:0] {
        TOK_HEX_0  = 5'd0,
        TOK_HEX_9  = 5'd9,
        TOK_HEX_A  = 5'd10,
        TOK_HEX_F  = 5'd15,
        TOK_LPAREN = 5'd16,
        TOK_RPAREN = 5'd17,
        TOK_MUL    = 5'd18,
        TOK_ADD    = 5'd19,
        TOK_SUB    = 5'd20
    } aec_tok_e;

    localparam logic [7:0] ASCII_NUL    = 8'h00;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_LC_A   = 8'h61;
    localparam logic [7:0] ASCII_LPAREN = 8'h28;
    localparam logic [7:0] ASCII_RPAREN = 8'h29;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_EQ     = 8'h3D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } aec_state_e;

    // Codes above TOK_SUB are accepted on the bus but carry no character.
    function automatic logic tok_is_valid(input logic [4:0] code);
        return (code <= 5'd20);
    endfunction

endpackage

// File: rtl/aec_tok2ascii.sv
// Combinational token-code to ASCII translation; unknown codes map to NUL.
module aec_tok2ascii
    import aec_pkg::*;
(
    input  logic [4:0] code,
    output logic [7:0] ascii
);

    // Digits and lower-case hex letters are offsets from their base character.
    always_comb begin
        ascii = ASCII_NUL;
        if (code <= 5'd9) begin
            ascii = ASCII_ZERO + {3'b000, code};
        end else if (code <= 5'd15) begin
            ascii = ASCII_LC_A + {3'b000, code - 5'd10};
        end else begin
            case (code)
                5'd16:   ascii = ASCII_LPAREN;
                5'd17:   ascii = ASCII_RPAREN;
                5'd18:   ascii = ASCII_STAR;
                5'd19:   ascii = ASCII_PLUS;
                5'd20:   ascii = ASCII_MINUS;
                default: ascii = ASCII_NUL;
            endcase
        end
    end

endmodule

// File: rtl/aec_tx.sv
// Buffers an expression token by token, then streams it as ASCII followed by '=' and waits for done.
// Define AEC_TX_PAREN_CHECK_EN to reject frames with unbalanced parentheses.
module aec_tx
    import aec_pkg::*;
#(
    parameter int DEPTH = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tok_valid,
    input  logic [4:0] tok_in,
    input  logic       tok_last,
    output logic       tok_ready,
    input  logic       done,
    output logic       ready,
    output logic [7:0] ascii_out,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(DEPTH + 2);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = 1 << IW;

    aec_state_e      state_r;
    logic [4:0]      buf_r [BW];
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   idx_r;
    logic            tok_ready_r;
    logic            ready_r;
    logic [7:0]      ascii_r;
    logic            busy_r;
    logic            err_r;

    logic            accept_s;
    logic            tok_ok_s;
    logic [CW-1:0]   count_nxt_s;
    logic            frame_end_s;
    logic            start_s;
    logic            drop_s;
    logic [4:0]      code_s;
    logic [7:0]      char_s;

`ifdef AEC_TX_PAREN_CHECK_EN
    logic [3:0]      depth_r;
    logic [3:0]      depth_nxt_s;
    logic            under_s;
`endif

    assign tok_ready = tok_ready_r;
    assign ready     = ready_r;
    assign ascii_out = ascii_r;
    assign busy      = busy_r;
    assign err       = err_r;

    // Acceptance bookkeeping and frame-start decision for the current cycle.
    always_comb begin
        accept_s    = tok_valid && (state_r == IDLE);
        tok_ok_s    = tok_is_valid(tok_in);
        count_nxt_s = count_r + {{(CW-1){1'b0}}, (accept_s && tok_ok_s)};
        frame_end_s = accept_s && (tok_last || (count_nxt_s == CW'(DEPTH)));
        start_s     = frame_end_s && (count_nxt_s != {CW{1'b0}});
    end

`ifdef AEC_TX_PAREN_CHECK_EN
    // Paren depth after this cycle's token; a ')' at depth zero is an underflow.
    always_comb begin
        depth_nxt_s = depth_r;
        under_s     = 1'b0;
        if (accept_s && (tok_in == 5'd16)) begin
            depth_nxt_s = depth_r + 4'd1;
        end else if (accept_s && (tok_in == 5'd17)) begin
            if (depth_r == 4'd0) begin
                under_s = 1'b1;
            end else begin
                depth_nxt_s = depth_r - 4'd1;
            end
        end else begin
            depth_nxt_s = depth_r;
        end
        drop_s = under_s || (frame_end_s && (depth_nxt_s != 4'd0));
    end

    // Depth counter restarts with every new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_r <= 4'd0;
        end else if (drop_s || start_s) begin
            depth_r <= 4'd0;
        end else if (state_r == IDLE) begin
            depth_r <= depth_nxt_s;
        end else begin
            depth_r <= depth_r;
        end
    end
`else
    assign drop_s = 1'b0;
`endif

    // The first character comes from the incoming token when the buffer is still empty.
    always_comb begin
        code_s = 5'd0;
        if (state_r == SEND) begin
            if (idx_r < count_r) begin
                code_s = buf_r[idx_r[IW-1:0]];
            end else begin
                code_s = 5'd0;
            end
        end else if (count_r == {CW{1'b0}}) begin
            code_s = tok_in;
        end else begin
            code_s = buf_r[0];
        end
    end

    aec_tok2ascii u_tok2ascii (
        .code  (code_s),
        .ascii (char_s)
    );

    // Frame FSM with all handshake and character outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            idx_r       <= {CW{1'b0}};
            tok_ready_r <= 1'b1;
            ready_r     <= 1'b0;
            ascii_r     <= ASCII_NUL;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            for (int i = 0; i < BW; i++) begin
                buf_r[i] <= 5'd0;
            end
        end else begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && tok_ok_s && (count_r < CW'(DEPTH))) begin
                        buf_r[count_r[IW-1:0]] <= tok_in;
                    end
                    err_r <= accept_s && (!tok_ok_s || drop_s);
                    if (drop_s) begin
                        count_r <= {CW{1'b0}};
                        ascii_r <= ASCII_NUL;
                    end else if (start_s) begin
                        state_r     <= SEND;
                        count_r     <= count_nxt_s;
                        idx_r       <= CW'(1);
                        ready_r     <= 1'b1;
                        ascii_r     <= char_s;
                        busy_r      <= 1'b1;
                        tok_ready_r <= 1'b0;
                    end else begin
                        count_r <= count_nxt_s;
                        ascii_r <= ASCII_NUL;
                    end
                end
                SEND: begin
                    // idx_r runs one past the last token so '=' gets its own cycle.
                    if (idx_r < count_r) begin
                        ascii_r <= char_s;
                        idx_r   <= idx_r + CW'(1);
                    end else if (idx_r == count_r) begin
                        ascii_r <= ASCII_EQ;
                        idx_r   <= idx_r + CW'(1);
                    end else begin
                        state_r <= WAIT;
                        ascii_r <= ASCII_NUL;
                    end
                end
                WAIT: begin
                    ascii_r <= ASCII_NUL;
                    if (done) begin
                        state_r     <= IDLE;
                        count_r     <= {CW{1'b0}};
                        idx_r       <= {CW{1'b0}};
                        busy_r      <= 1'b0;
                        tok_ready_r <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    count_r     <= {CW{1'b0}};
                    idx_r       <= {CW{1'b0}};
                    tok_ready_r <= 1'b1;
                    ascii_r     <= ASCII_NUL;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
